// File: rtl/iter_alu.sv
// rtl/iter_alu.sv - registered ALU with iterative shift-add multiply and restoring divide
// Define ITER_ALU_DIV_EN to build the DIV/DIVU datapath; otherwise those opcodes return 0.
module iter_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ctrl,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             zero
);
  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_SLT  = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_NOR  = 4'b0110;
  localparam logic [3:0] OP_SLTU = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL
`ifdef ITER_ALU_DIV_EN
    , S_DIV
`endif
  } state_t;

  state_t                 state_q, state_d;
  logic [2*WIDTH-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]       mcand_q, mcand_d;
  logic [SHW-1:0]         cnt_q, cnt_d;
  logic                   neg_q, neg_d;
  logic [WIDTH-1:0]       result_d, hi_d;
  logic                   out_valid_d;
  logic                   accept, is_mul, is_signed;
  logic [SHW-1:0]         shamt;
  logic [WIDTH-1:0]       mag1, mag2, alu_res;
  logic [WIDTH:0]         mul_sum;
  logic [2*WIDTH-1:0]     mul_next, mul_fix;

  assign in_ready  = (state_q == S_IDLE) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign is_mul    = (ctrl[3:1] == 3'b110);
  assign is_signed = !ctrl[0];
  assign shamt     = src2[SHW-1:0];
  assign mag1      = (is_signed && src1[WIDTH-1]) ? -src1 : src1;
  assign mag2      = (is_signed && src2[WIDTH-1]) ? -src2 : src2;
  assign zero      = (result == '0);

  // acc holds {partial product, remaining multiplier bits}; one multiplier bit retires per cycle.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};
  assign mul_fix  = neg_q ? -mul_next : mul_next;

`ifdef ITER_ALU_DIV_EN
  logic               is_div, negr_q, negr_d;
  logic [WIDTH:0]     div_shift, div_diff;
  logic [2*WIDTH-1:0] div_next;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // acc holds {partial remainder, dividend bits shifting out / quotient bits shifting in}.
  assign is_div    = (ctrl[3:1] == 3'b111);
  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, mcand_q};
  assign div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                     : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
  assign quo_fix   = neg_q  ? -div_next[WIDTH-1:0] : div_next[WIDTH-1:0];
  assign rem_fix   = negr_q ? -div_next[2*WIDTH-1:WIDTH] : div_next[2*WIDTH-1:WIDTH];
`endif

  always_comb begin
    alu_res = '0;
    case (ctrl)
      OP_AND:  alu_res = src1 & src2;
      OP_OR:   alu_res = src1 | src2;
      OP_ADD:  alu_res = src1 + src2;
      OP_SUB:  alu_res = src1 - src2;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(src1) < $signed(src2))};
      OP_XOR:  alu_res = src1 ^ src2;
      OP_NOR:  alu_res = ~(src1 | src2);
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (src1 < src2)};
      OP_SLL:  alu_res = src1 << shamt;
      OP_SRL:  alu_res = src1 >> shamt;
      OP_SRA:  alu_res = $signed(src1) >>> shamt;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    cnt_d       = cnt_q;
    neg_d       = neg_q;
    result_d    = result;
    hi_d        = hi;
    out_valid_d = out_valid && !out_ready;
`ifdef ITER_ALU_DIV_EN
    negr_d      = negr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          cnt_d = '0;
          if (is_mul) begin
            state_d = S_MUL;
            acc_d   = {{WIDTH{1'b0}}, mag2};
            mcand_d = mag1;
            neg_d   = is_signed && (src1[WIDTH-1] ^ src2[WIDTH-1]);
          end
`ifdef ITER_ALU_DIV_EN
          else if (is_div && (src2 == '0)) begin
            result_d    = '1;
            hi_d        = src1;
            out_valid_d = 1'b1;
          end else if (is_div) begin
            state_d = S_DIV;
            acc_d   = {{WIDTH{1'b0}}, mag1};
            mcand_d = mag2;
            neg_d   = is_signed && (src1[WIDTH-1] ^ src2[WIDTH-1]);
            negr_d  = is_signed && src1[WIDTH-1];
          end
`endif
          else begin
            result_d    = alu_res;
            hi_d        = '0;
            out_valid_d = 1'b1;
          end
        end
      end
      S_MUL: begin
        acc_d = mul_next;
        cnt_d = cnt_q + SHW'(1);
        if (cnt_q == LAST) begin
          {hi_d, result_d} = mul_fix;
          out_valid_d      = 1'b1;
          state_d          = S_IDLE;
        end
      end
`ifdef ITER_ALU_DIV_EN
      S_DIV: begin
        acc_d = div_next;
        cnt_d = cnt_q + SHW'(1);
        if (cnt_q == LAST) begin
          result_d    = quo_fix;
          hi_d        = rem_fix;
          out_valid_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      result    <= '0;
      hi        <= '0;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      result    <= result_d;
      hi        <= hi_d;
      out_valid <= out_valid_d;
    end
  end

`ifdef ITER_ALU_DIV_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) negr_q <= 1'b0;
    else        negr_q <= negr_d;
  end
`endif

endmodule

// File: tb/tb_iter_alu.sv
// tb/tb_iter_alu.sv - self-checking bench for iter_alu: directed cases plus random ops vs. arithmetic model
// Honours ITER_ALU_DIV_EN to select divider expectations.
module tb_iter_alu;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  ctrl;
  logic [31:0] src1, src2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result, hi;
  logic        zero;

  int checks = 0;
  int errors = 0;

  iter_alu #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ctrl(ctrl), .src1(src1), .src2(src2), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .hi(hi), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected {hi, result} and latency straight from the opcode definitions.
  task automatic ref_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output logic [31:0] h, output int lat);
    longint     sa, sb, q, m;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = 32'd0; h = 32'd0; lat = 1;
    case (op)
      4'd0:  r = a & b;
      4'd1:  r = a | b;
      4'd2:  r = a + b;
      4'd3:  r = a - b;
      4'd4:  r = (sa < sb) ? 32'd1 : 32'd0;
      4'd5:  r = a ^ b;
      4'd6:  r = ~(a | b);
      4'd7:  r = (a < b) ? 32'd1 : 32'd0;
      4'd8:  r = a << b[4:0];
      4'd9:  r = a >> b[4:0];
      4'd10: r = $signed(a) >>> b[4:0];
      4'd12: begin p = 64'(sa * sb); {h, r} = p; lat = 33; end
      4'd13: begin p = {32'd0, a} * {32'd0, b}; {h, r} = p; lat = 33; end
`ifdef ITER_ALU_DIV_EN
      4'd14: if (b == 0) begin r = '1; h = a; end
             else begin q = sa / sb; m = sa % sb; r = q[31:0]; h = m[31:0]; lat = 33; end
      4'd15: if (b == 0) begin r = '1; h = a; end
             else begin r = a / b; h = a % b; lat = 33; end
`endif
      default: ;
    endcase
  endtask

  // Issue one op, keep junk requests pending while busy, then check latency, outputs and drain.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic [31:0] eh, input int elat, input string tag);
    int n;
    bit busy_ok;
    in_valid = 1'b1; ctrl = op; src1 = a; src2 = b; out_ready = 1'b0;
    #1;
    chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    ctrl = 4'd2; src1 = 32'h1111_1111; src2 = 32'h2222_2222;
    n = 1;
    busy_ok = 1'b1;
    while (out_valid !== 1'b1 && n < 100) begin
      if (in_ready !== 1'b0) busy_ok = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    chk({tag, ".latency"}, 64'(n), 64'(elat));
    chk({tag, ".busy"}, 64'(busy_ok && in_ready === 1'b0), 64'd1);
    chk({tag, ".result"}, 64'(result), 64'(er));
    chk({tag, ".hi"}, 64'(hi), 64'(eh));
    chk({tag, ".zero"}, 64'(zero), 64'(er == 32'd0));
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, ".drained"}, 64'(out_valid), 64'd0);
  endtask

  task automatic run_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [31:0] er, eh;
    int el;
    ref_op(op, a, b, er, eh, el);
    run_op(op, a, b, er, eh, el, tag);
  endtask

  initial begin
    logic [31:0] held;
    bit quiet;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; ctrl = 4'd0; src1 = '0; src2 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.result", 64'(result), 64'd0);
    chk("rst.hi", 64'(hi), 64'd0);
    chk("rst.zero", 64'(zero), 64'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle.in_ready", 64'(in_ready), 64'd1);

    run_op(4'd2,  32'h7FFF_FFFF, 32'd1,        32'h8000_0000, 32'd0, 1,  "add_wrap");
    run_op(4'd4,  32'hFFFF_FFFF, 32'd1,        32'd1,         32'd0, 1,  "slt");
    run_op(4'd3,  32'd5,         32'd5,        32'd0,         32'd0, 1,  "sub_zero");
    run_op(4'd10, 32'h8000_0000, 32'd4,        32'hF800_0000, 32'd0, 1,  "sra");
    run_op(4'd7,  32'hFFFF_FFFF, 32'd1,        32'd0,         32'd0, 1,  "sltu");
    run_op(4'd8,  32'hDEAD_BEEF, 32'h0000_0020, 32'hDEAD_BEEF, 32'd0, 1, "sll_by0");
    run_op(4'd11, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0,        32'd0, 1,  "reserved");
    run_op(4'd12, 32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFEB, 32'hFFFF_FFFF, 33, "mult");
    run_op(4'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 33, "multu");
`ifdef ITER_ALU_DIV_EN
    run_op(4'd14, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, "div_neg");
    run_op(4'd15, 32'd7,         32'd0,        32'hFFFF_FFFF, 32'd7,         1,  "divu_by0");
    run_op(4'd14, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,        33, "div_ovf");
    run_op(4'd15, 32'd100,       32'd7,        32'd14,        32'd2,         33, "divu");
`else
    run_op(4'd14, 32'hFFFF_FFF9, 32'd2,        32'd0,         32'd0,         1,  "div_off");
    run_op(4'd15, 32'd7,         32'd0,        32'd0,         32'd0,         1,  "divu_off");
`endif

    // Backpressure: result held for 5 cycles, then drain and accept together.
    in_valid = 1'b1; ctrl = 4'd1; src1 = 32'h00F0_0000; src2 = 32'h0000_000F;
    #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    held = 32'h00F0_000F;
    for (int c = 0; c < 5; c++) begin
      chk("hold.valid", 64'(out_valid), 64'd1);
      chk("hold.result", 64'(result), 64'(held));
      chk("hold.in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1; in_valid = 1'b1; ctrl = 4'd5; src1 = 32'hA5A5_A5A5; src2 = 32'h0F0F_0F0F;
    #1;
    chk("both.in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    chk("both.valid", 64'(out_valid), 64'd1);
    chk("both.result", 64'(result), 64'hAAAA_AAAA);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset in the middle of an unsigned multiply.
    in_valid = 1'b1; ctrl = 4'd13; src1 = 32'h0001_2345; src2 = 32'h0000_6789;
    #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("midrst.out_valid", 64'(out_valid), 64'd0);
    chk("midrst.result", 64'(result), 64'd0);
    chk("midrst.hi", 64'(hi), 64'd0);
    chk("midrst.zero", 64'(zero), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    quiet = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) quiet = 1'b0;
    end
    chk("midrst.aborted", 64'(quiet), 64'd1);
    run_op(4'd0, 32'h0000_00F0, 32'h0000_003C, 32'h0000_0030, 32'd0, 1, "and_after_rst");

    for (int i = 0; i < 48; i++) begin
      logic [3:0]  op;
      logic [31:0] a, b;
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'($urandom_range(0, 3));
        1: b = 32'hFFFF_FFFF;
        2: a = 32'h8000_0000;
        3: a = 32'($urandom_range(0, 255));
        default: ;
      endcase
      run_model(op, a, b, $sformatf("rand%0d_op%0d", i, op));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
